// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with valid/ready handshakes on the
// operand and result sides. One operation runs WIDTH+1 Booth iterations
// over a WIDTH+2 bit accumulator. The guard bit keeps A-M from overflowing
// when M is the most negative operand. Extending unsigned operands by one
// zero bit lets the same iteration count serve signed and unsigned modes.
module booth_mult_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    input  logic                 sgn,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int AW = WIDTH + 2;
    localparam int QW = WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EVAL  = 3'd1,
        SUB   = 3'd2,
        ADD   = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t              state_reg, state_next;
    logic [AW-1:0]       a_reg, a_next;
    logic [AW-1:0]       m_reg, m_next;
    logic [QW-1:0]       q_reg, q_next;
    logic                q_m1_reg, q_m1_next;
    logic [CW-1:0]       cnt_reg, cnt_next;
    logic [2*WIDTH-1:0]  product_reg, product_next;

    // Operands extended to datapath width: the upper bits copy the operand
    // MSB in signed mode and are zero in unsigned mode.
    logic [AW-1:0]       a_ext;
    logic [QW-1:0]       b_ext;

    assign a_ext[WIDTH-1:0] = a_in;
    assign b_ext[WIDTH-1:0] = b_in;
    assign b_ext[WIDTH]     = sgn & b_in[WIDTH-1];

    generate
        for (genvar gi = WIDTH; gi < AW; gi++) begin : g_a_ext
            assign a_ext[gi] = sgn & a_in[WIDTH-1];
        end
    endgenerate

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            m_reg       <= '0;
            q_reg       <= '0;
            q_m1_reg    <= 1'b0;
            cnt_reg     <= '0;
            product_reg <= '0;
        end else begin
            state_reg   <= state_next;
            a_reg       <= a_next;
            m_reg       <= m_next;
            q_reg       <= q_next;
            q_m1_reg    <= q_m1_next;
            cnt_reg     <= cnt_next;
            product_reg <= product_next;
        end
    end

    // Next-state logic: Booth recoding of {Q[0], q_m1} picks the step.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    state_next = EVAL;
                end
            end
            EVAL: begin
                if (cnt_reg == '0) begin
                    state_next = DONE;
                end else begin
                    case ({q_reg[0], q_m1_reg})
                        2'b10:   state_next = SUB;
                        2'b01:   state_next = ADD;
                        default: state_next = SHIFT;
                    endcase
                end
            end
            SUB:     state_next = SHIFT;
            ADD:     state_next = SHIFT;
            SHIFT:   state_next = EVAL;
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath updates for each state; product only changes on EVAL->DONE.
    always_comb begin
        a_next       = a_reg;
        m_next       = m_reg;
        q_next       = q_reg;
        q_m1_next    = q_m1_reg;
        cnt_next     = cnt_reg;
        product_next = product_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    a_next    = '0;
                    m_next    = a_ext;
                    q_next    = b_ext;
                    q_m1_next = 1'b0;
                    cnt_next  = CW'(WIDTH + 1);
                end
            end
            EVAL: begin
                if (cnt_reg == '0) begin
                    // Low 2*WIDTH bits of {A,Q}; the true product always fits.
                    product_next = {a_reg[WIDTH-2:0], q_reg};
                end
            end
            SUB: a_next = a_reg - m_reg;
            ADD: a_next = a_reg + m_reg;
            SHIFT: begin
                {a_next, q_next, q_m1_next} = {a_reg[AW-1], a_reg, q_reg};
                cnt_next = cnt_reg - 1'b1;
            end
            default: ;
        endcase
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        in_ready  = (state_reg == IDLE) && !rst;
        out_valid = (state_reg == DONE);
        busy      = (state_reg != IDLE);
        product   = product_reg;
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq: a table of 8-bit operations, 16-bit
// latency and product checks, backpressure with a back-to-back operand,
// and a reset in the middle of an operation.
module tb_booth_mult_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid8 = 1'b0, in_ready8, sgn8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        out_valid8, out_ready8 = 1'b0, busy8;
    logic [15:0] product8;

    logic        in_valid16 = 1'b0, in_ready16, sgn16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        out_valid16, out_ready16 = 1'b0, busy16;
    logic [31:0] product16;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    booth_mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a_in(a8), .b_in(b8), .sgn(sgn8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .product(product8), .busy(busy8)
    );

    booth_mult_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .a_in(a16), .b_in(b16), .sgn(sgn16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .product(product16), .busy(busy16)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Latency = 2*(WIDTH+1) + number of ADD/SUB steps + 1, where the
    // ADD/SUB steps are the bit changes scanned across {ext(b), 0}.
    function automatic int lat8(input logic [7:0] b, input logic s);
        logic [8:0] q;
        int n;
        logic prev;
        q = {s & b[7], b};
        n = 0;
        prev = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (q[i] != prev) n++;
            prev = q[i];
        end
        return 2 * 9 + n + 1;
    endfunction

    function automatic int lat16(input logic [15:0] b, input logic s);
        logic [16:0] q;
        int n;
        logic prev;
        q = {s & b[15], b};
        n = 0;
        prev = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (q[i] != prev) n++;
            prev = q[i];
        end
        return 2 * 17 + n + 1;
    endfunction

    // Present operands once in_ready is high; returns after the accept edge.
    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic s);
        int k;
        k = 0;
        while (!in_ready8 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (!in_ready8) begin
            checks++;
            failures++;
            $display("FAIL start8_timeout: in_ready got 0 expected 1");
        end
        a8 = a; b8 = b; sgn8 = s; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    // Count edges from the accept edge until out_valid is seen.
    task automatic wait_done8(output int lat);
        lat = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid8) return;
        end
        checks++;
        failures++;
        $display("FAIL wait_done8_timeout: out_valid got 0 expected 1");
    endtask

    task automatic take8;
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic s,
                         output logic [31:0] prod, output int lat);
        int k;
        k = 0;
        while (!in_ready16 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        a16 = a; b16 = b; sgn16 = s; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        lat = 0;
        prod = '0;
        for (int j = 0; j < 100; j++) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid16) break;
        end
        prod = product16;
        out_ready16 = 1'b1;
        @(posedge clk); #1;
        out_ready16 = 1'b0;
    endtask

    vec_t vecs[11];

    initial begin
        int lat;
        logic [31:0] p16;
        logic seen;

        vecs[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        vecs[1]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
        vecs[2]  = '{8'hFD, 8'h05, 1'b1, 16'hFFF1};
        vecs[3]  = '{8'hFD, 8'h05, 1'b0, 16'h04F1};
        vecs[4]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
        vecs[5]  = '{8'h80, 8'h7F, 1'b1, 16'hC080};
        vecs[6]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
        vecs[7]  = '{8'h00, 8'hAB, 1'b0, 16'h0000};
        vecs[8]  = '{8'h12, 8'h34, 1'b0, 16'h03A8};
        vecs[9]  = '{8'h80, 8'h01, 1'b0, 16'h0080};
        vecs[10] = '{8'hFF, 8'h80, 1'b1, 16'h0080};

        // Reset state, including in_ready held low while rst is high.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready8), 64'd0);
        chk("rst_out_valid", 64'(out_valid8), 64'd0);
        chk("rst_busy", 64'(busy8), 64'd0);
        chk("rst_product", 64'(product8), 64'd0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 64'(in_ready8), 64'd1);

        // Table-driven 8-bit operations.
        foreach (vecs[i]) begin
            start8(vecs[i].a, vecs[i].b, vecs[i].s);
            wait_done8(lat);
            $display("op8 a=%02h b=%02h sgn=%0d product=%04h latency=%0d",
                     vecs[i].a, vecs[i].b, vecs[i].s, product8, lat);
            chk($sformatf("vec%0d_product", i), 64'(product8), 64'(vecs[i].exp));
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(lat8(vecs[i].b, vecs[i].s)));
            if (i == 0) chk("vec0_within_28", 64'(lat <= 28), 64'd1);
            take8();
        end

        // 16-bit: b=0 gives the minimum latency 2*WIDTH+3 = 35.
        run16(16'h0000, 16'h0000, 1'b1, p16, lat);
        $display("op16 a=0000 b=0000 product=%08h latency=%0d", p16, lat);
        chk("w16_zero_product", 64'(p16), 64'd0);
        chk("w16_zero_latency", 64'(lat), 64'd35);
        // b=0x1234 still has Booth recoding transitions, so its latency
        // includes those ADD/SUB steps even though a=0.
        run16(16'h0000, 16'h1234, 1'b1, p16, lat);
        $display("op16 a=0000 b=1234 product=%08h latency=%0d", p16, lat);
        chk("w16_a0_product", 64'(p16), 64'd0);
        chk("w16_a0_latency", 64'(lat), 64'(lat16(16'h1234, 1'b1)));
        run16(16'h8000, 16'h8000, 1'b1, p16, lat);
        $display("op16 a=8000 b=8000 product=%08h latency=%0d", p16, lat);
        chk("w16_minneg_product", 64'(p16), 64'h40000000);
        run16(16'hFFFD, 16'h0005, 1'b1, p16, lat);
        $display("op16 a=FFFD b=0005 product=%08h latency=%0d", p16, lat);
        chk("w16_neg_product", 64'(p16), 64'hFFFFFFF1);

        // Backpressure: result held, new operands ignored while DONE.
        start8(8'h0C, 8'h0D, 1'b0);
        wait_done8(lat);
        a8 = 8'hFF; b8 = 8'hFF; sgn8 = 1'b1; in_valid8 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            $display("backpressure cycle=%0d out_valid=%0d product=%04h in_ready=%0d",
                     c, out_valid8, product8, in_ready8);
            chk("bp_out_valid", 64'(out_valid8), 64'd1);
            chk("bp_product", 64'(product8), 64'h009C);
            chk("bp_in_ready", 64'(in_ready8), 64'd0);
        end
        // Handshake with the next operand already waiting.
        a8 = 8'h0B; b8 = 8'h0B; sgn8 = 1'b0;
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        chk("hs_out_valid", 64'(out_valid8), 64'd0);
        chk("hs_in_ready", 64'(in_ready8), 64'd1);
        chk("hs_product_held", 64'(product8), 64'h009C);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        chk("b2b_busy", 64'(busy8), 64'd1);
        wait_done8(lat);
        $display("op8 back-to-back a=0b b=0b product=%04h latency=%0d", product8, lat);
        chk("b2b_product", 64'(product8), 64'h0079);
        chk("b2b_latency", 64'(lat), 64'(lat8(8'h0B, 1'b0)));
        take8();

        // Reset in the middle of an operation.
        start8(8'h55, 8'h33, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 64'(in_ready8), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        $display("mid-op reset busy=%0d out_valid=%0d product=%04h", busy8, out_valid8, product8);
        chk("midrst_busy", 64'(busy8), 64'd0);
        chk("midrst_out_valid", 64'(out_valid8), 64'd0);
        chk("midrst_product", 64'(product8), 64'd0);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (out_valid8) seen = 1'b1;
        end
        chk("midrst_no_result", 64'(seen), 64'd0);
        start8(8'h07, 8'h09, 1'b1);
        wait_done8(lat);
        $display("op8 after reset a=07 b=09 product=%04h latency=%0d", product8, lat);
        chk("postrst_product", 64'(product8), 64'h003F);
        take8();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
